// File: rtl/cdc_src_fifo_pkg.sv
// Shared constants for the source-side CDC buffer and the handshake synchronizer.
// Holds the default word width, a constant clog2, and the handshake port widths.
// No logic; both sides import this so their port widths cannot drift apart.
package cdc_src_fifo_pkg;

  localparam int data_width_def = 8;

  // Handshake port widths shared by the FIFO output and the synchronizer input
  localparam int hs_data_w  = data_width_def;
  localparam int hs_valid_w = 1;
  localparam int hs_busy_w  = 1;

  // Ceiling log2 for sizing pointers; clog2(1) is 0
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cdc_fifo_mem.sv
// Storage array for the source FIFO: registered write port, combinational read port.
// Write lands on the clock edge; read data follows rd_addr with zero cycles.
// No backpressure of its own; the caller gates wr_en. Contents are not reset.
module cdc_fifo_mem #(
  parameter int data_width = 8,
  parameter int depth      = 4,
  parameter int addr_w     = 2
) (
  input  logic                  i_clk,
  input  logic                  wr_en,
  input  logic [addr_w-1:0]     wr_addr,
  input  logic [data_width-1:0] wr_data,
  input  logic [addr_w-1:0]     rd_addr,
  output logic [data_width-1:0] rd_data
);

  logic [data_width-1:0] mem [depth];

  // Write port: one word per cycle when enabled
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/cdc_src_fifo.sv
// Source-domain FIFO feeding the 2-phase synchronizer one word per crossing.
// Latency: a word pushed into an empty FIFO is presented on m_valid/m_data the next cycle.
// Backpressure: s_ready drops when full; the head is only popped when m_busy is low.
module cdc_src_fifo
  import cdc_src_fifo_pkg::*;
#(
  parameter  int data_width = data_width_def,
  parameter  int depth      = 4,
  localparam int addr_w     = clog2(depth)
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic [data_width-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  i_flush,
  output logic [data_width-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_busy,
  output logic [addr_w:0]       level,
  output logic [addr_w:0]       hwm
);

  localparam logic [addr_w:0]   lvl_full = (addr_w + 1)'(depth);
  localparam logic [addr_w:0]   lvl_one  = (addr_w + 1)'(1);
  localparam logic [addr_w-1:0] ptr_one  = addr_w'(1);

  logic [addr_w-1:0] wr_ptr;
  logic [addr_w-1:0] rd_ptr;
  logic [addr_w:0]   level_nxt;
  logic              push;
  logic              pop;

  // Ready/valid come from the registered count only, so nothing combinational
  // passes from the producer to the synchronizer or back.
  assign s_ready = i_rstn & (level != lvl_full);
  assign m_valid = (level != '0);

  // A pop mirrors the synchronizer's capture rule: it latches when valid & ~busy.
  assign push = s_valid & s_ready;
  assign pop  = m_valid & ~m_busy;

  // Occupancy after this cycle's handshakes; push+pop together leave it unchanged
  always_comb begin
    level_nxt = level;
    if (push && !pop)      level_nxt = level + lvl_one;
    else if (pop && !push) level_nxt = level - lvl_one;
  end

  // Pointers, occupancy and high-water mark; reset wins over flush, flush drops handshakes
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      hwm    <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      hwm    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptr_one;
      if (pop)  rd_ptr <= rd_ptr + ptr_one;
      level <= level_nxt;
      if (level_nxt > hwm) hwm <= level_nxt;
    end
  end

  cdc_fifo_mem #(
    .data_width (data_width),
    .depth      (depth),
    .addr_w     (addr_w)
  ) u_mem (
    .i_clk   (i_clk),
    .wr_en   (push & ~i_flush),
    .wr_addr (wr_ptr),
    .wr_data (s_data),
    .rd_addr (rd_ptr),
    .rd_data (m_data)
  );

  // Occupancy stays within 0..depth
  a_level_max: assert property (@(posedge i_clk) disable iff (!i_rstn) level <= lvl_full);
  a_no_underflow: assert property (@(posedge i_clk) disable iff (!i_rstn) !(pop && level == '0));

  // The synchronizer may resample data while busy, so the head must hold still
  a_data_stable: assert property (@(posedge i_clk)
    (i_rstn && !i_flush && m_valid && m_busy) |=> $stable(m_data));

endmodule

// File: tb/tb_cdc_src_fifo.sv
module tb_cdc_src_fifo;

  logic       i_clk;
  logic       i_rstn;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       i_flush;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_busy;
  logic [2:0] level;
  logic [2:0] hwm;

  int n_checks;
  int n_fail;

  cdc_src_fifo #(.data_width(8), .depth(4)) dut (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .i_flush (i_flush),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_busy  (m_busy),
    .level   (level),
    .hwm     (hwm)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Advance one cycle and settle just past the edge
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rstn = 1'b0; i_flush = 1'b0; s_valid = 1'b1; s_data = 8'h5A; m_busy = 1'b0;
    #1;
    n_checks++;
    if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready: got %b expected 0", s_ready); end
    tick(); tick();
    n_checks++;
    if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
    n_checks++;
    if (hwm !== 3'd0) begin n_fail++; $display("FAIL reset_hwm: got %0d expected 0", hwm); end
    n_checks++;
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
    s_valid = 1'b0;
    i_rstn  = 1'b1;
    tick();
    n_checks++;
    if (s_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_s_ready: got %b expected 1", s_ready); end
  endtask

  task automatic test_single_word();
    m_busy = 1'b0; s_data = 8'hA5; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    n_checks++;
    if (m_valid !== 1'b1 || m_data !== 8'hA5) begin
      n_fail++; $display("FAIL single_head: got v=%b d=%h expected v=1 d=a5", m_valid, m_data);
    end
    n_checks++;
    if (level !== 3'd1) begin n_fail++; $display("FAIL single_level1: got %0d expected 1", level); end
    tick();
    n_checks++;
    if (level !== 3'd0 || m_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_drained: got level=%0d v=%b expected 0/0", level, m_valid);
    end
    n_checks++;
    if (hwm !== 3'd1) begin n_fail++; $display("FAIL single_hwm: got %0d expected 1", hwm); end
  endtask

  task automatic test_burst_full();
    m_busy = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      s_data  = 8'(i);
      s_valid = 1'b1;
      n_checks++;
      if (s_ready !== (i <= 4)) begin
        n_fail++; $display("FAIL burst_s_ready word %0d: got %b expected %b", i, s_ready, (i <= 4));
      end
      tick();
    end
    n_checks++;
    if (level !== 3'd4 || hwm !== 3'd4) begin
      n_fail++; $display("FAIL burst_full: got level=%0d hwm=%0d expected 4/4", level, hwm);
    end
    n_checks++;
    if (m_data !== 8'h01) begin n_fail++; $display("FAIL burst_head: got %h expected 01", m_data); end
  endtask

  // Synchronizer model: busy rises the cycle after each pop and stays high 6 cycles.
  // The producer keeps 0x05 offered until it is accepted.
  task automatic test_drain_busy();
    int got, busy_cnt, exp_lvl;
    logic pop_now, push_now;
    got = 0; busy_cnt = 0; exp_lvl = 4;
    m_busy = 1'b0;
    for (int c = 0; c < 200 && got < 5; c++) begin
      pop_now  = (exp_lvl != 0) && !m_busy;
      push_now = s_valid && (exp_lvl != 4);
      if (pop_now) begin
        n_checks++;
        if (m_data !== 8'(got + 1)) begin
          n_fail++; $display("FAIL drain_order idx %0d: got %h expected %h", got, m_data, 8'(got + 1));
        end
        got++;
      end
      exp_lvl = exp_lvl + (push_now ? 1 : 0) - (pop_now ? 1 : 0);
      tick();
      n_checks++;
      if (level !== 3'(exp_lvl)) begin
        n_fail++; $display("FAIL drain_level cycle %0d: got %0d expected %0d", c, level, exp_lvl);
      end
      if (push_now) s_valid = 1'b0;
      if (pop_now) begin
        m_busy = 1'b1; busy_cnt = 6;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) m_busy = 1'b0;
      end
    end
    n_checks++;
    if (got != 5) begin n_fail++; $display("FAIL drain_count: got %0d expected 5", got); end
    m_busy = 1'b0;
    n_checks++;
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got v=%b expected 0", m_valid); end
  endtask

  task automatic test_wrap();
    int sent, rcv, exp_lvl;
    logic pu, po;
    sent = 0; rcv = 0; exp_lvl = 0;
    for (int c = 0; c < 80 && rcv < 10; c++) begin
      s_valid = (sent < 10);
      s_data  = 8'(8'h10 + sent);
      m_busy  = (c % 3 == 0) || (c % 7 == 1);
      n_checks++;
      if (s_ready !== (exp_lvl != 4) || m_valid !== (exp_lvl != 0)) begin
        n_fail++; $display("FAIL wrap_flags cycle %0d: got rdy=%b v=%b for level %0d", c, s_ready, m_valid, exp_lvl);
      end
      pu = s_valid && (exp_lvl != 4);
      po = (exp_lvl != 0) && !m_busy;
      if (po) begin
        n_checks++;
        if (m_data !== 8'(8'h10 + rcv)) begin
          n_fail++; $display("FAIL wrap_order idx %0d: got %h expected %h", rcv, m_data, 8'(8'h10 + rcv));
        end
        rcv++;
      end
      if (pu) sent++;
      exp_lvl = exp_lvl + (pu ? 1 : 0) - (po ? 1 : 0);
      tick();
      n_checks++;
      if (level !== 3'(exp_lvl) || level > 3'd4) begin
        n_fail++; $display("FAIL wrap_level cycle %0d: got %0d expected %0d", c, level, exp_lvl);
      end
    end
    s_valid = 1'b0; m_busy = 1'b0;
    n_checks++;
    if (rcv != 10) begin n_fail++; $display("FAIL wrap_count: got %0d expected 10", rcv); end
  endtask

  task automatic test_simultaneous();
    m_busy = 1'b1; s_valid = 1'b1;
    s_data = 8'h31; tick();
    s_data = 8'h32; tick();
    s_data = 8'h33; m_busy = 1'b0; tick();
    n_checks++;
    if (level !== 3'd2 || m_data !== 8'h32) begin
      n_fail++; $display("FAIL simul_push_pop: got level=%0d head=%h expected 2/32", level, m_data);
    end
    m_busy = 1'b1;
    s_data = 8'h34; tick();
    s_data = 8'h35; tick();
    s_data = 8'h36; m_busy = 1'b0;
    n_checks++;
    if (level !== 3'd4 || s_ready !== 1'b0) begin
      n_fail++; $display("FAIL simul_full: got level=%0d rdy=%b expected 4/0", level, s_ready);
    end
    tick();
    s_valid = 1'b0; m_busy = 1'b1;
    n_checks++;
    if (level !== 3'd3 || m_data !== 8'h33) begin
      n_fail++; $display("FAIL simul_full_pop: got level=%0d head=%h expected 3/33", level, m_data);
    end
  endtask

  task automatic test_flush_reset();
    // Flush with a push and pop both offered: all of it is discarded
    i_flush = 1'b1; s_valid = 1'b1; s_data = 8'h66; m_busy = 1'b0;
    tick();
    i_flush = 1'b0; s_valid = 1'b0; m_busy = 1'b1;
    n_checks++;
    if (level !== 3'd0 || hwm !== 3'd0 || m_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush: got level=%0d hwm=%0d v=%b expected 0/0/0", level, hwm, m_valid);
    end
    s_valid = 1'b1; s_data = 8'h77;
    tick();
    s_valid = 1'b0;
    n_checks++;
    if (level !== 3'd1 || hwm !== 3'd1 || m_data !== 8'h77) begin
      n_fail++; $display("FAIL post_flush_push: got level=%0d hwm=%0d d=%h expected 1/1/77", level, hwm, m_data);
    end
    // Reset during a push, with flush also asserted
    i_rstn = 1'b0; i_flush = 1'b1; s_valid = 1'b1; s_data = 8'h88;
    #1;
    n_checks++;
    if (s_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_s_ready: got %b expected 0", s_ready); end
    tick();
    n_checks++;
    if (level !== 3'd0 || m_valid !== 1'b0 || hwm !== 3'd0) begin
      n_fail++; $display("FAIL rst_mid: got level=%0d v=%b hwm=%0d expected 0/0/0", level, m_valid, hwm);
    end
    s_valid = 1'b0; i_flush = 1'b0; i_rstn = 1'b1;
    tick();
    n_checks++;
    if (level !== 3'd0 || s_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_release: got level=%0d rdy=%b expected 0/1", level, s_ready);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single_word();
    test_burst_full();
    test_drain_busy();
    test_wrap();
    test_simultaneous();
    test_flush_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
